// File: rtl/axi_sram_pkg.sv
// Shared encodings for the AXI4-Lite to single-port SRAM bridge.
package axi_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACC  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ACC  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/axi_sram_chan_hold.sv
// One-entry capture register for an AXI request channel: ready while empty,
// loads the payload on valid&&ready, empties on a clear pulse.
module axi_sram_chan_hold
    import axi_sram_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         clear,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] q
);

    assign ready = !full;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            full <= 1'b0;
            q    <= '0;
        end else if (valid && ready) begin
            full <= 1'b1;
            q    <= data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite slave terminating into a single-port synchronous SRAM.
// Optional AXI_SRAM_SLAVE_RESP_EN adds axi_bresp/axi_rresp (SLVERR when out of range).
module axi_sram_slave #(
    parameter logic [31:0] MEM_BASE_ADDR   = 32'h8000_0000,
    parameter int          MEM_DEPTH_WORDS = 16384,
    parameter int          MEM_ADDR_W      = 14
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [31:0]           axi_awaddr,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [31:0]           axi_araddr,
    input  logic [2:0]            axi_arprot,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [31:0]           axi_rdata,
`ifdef AXI_SRAM_SLAVE_RESP_EN
    output logic [1:0]            axi_bresp,
    output logic [1:0]            axi_rresp,
`endif
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [3:0]            sram_strb,
    output logic [MEM_ADDR_W-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic [2:0]            dbg_state
);
    import axi_sram_pkg::*;

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH_WORDS) << 2;

    // Handshake rule on every channel: a transfer happens on the clock edge
    // where valid && ready are both high; bvalid/rvalid hold until accepted.
    logic        aw_full, w_full, ar_full;
    logic [31:0] aw_addr_q, ar_addr_q;
    logic [35:0] w_q;
    logic        b_hs, r_hs;

    assign b_hs = axi_bvalid && axi_bready;
    assign r_hs = axi_rvalid && axi_rready;

    axi_sram_chan_hold #(.W(32)) u_aw_hold (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(axi_awvalid), .data(axi_awaddr),
        .clear(b_hs), .ready(axi_awready), .full(aw_full), .q(aw_addr_q)
    );

    axi_sram_chan_hold #(.W(36)) u_w_hold (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(axi_wvalid), .data({axi_wstrb, axi_wdata}),
        .clear(b_hs), .ready(axi_wready), .full(w_full), .q(w_q)
    );

    axi_sram_chan_hold #(.W(32)) u_ar_hold (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(axi_arvalid), .data(axi_araddr),
        .clear(r_hs), .ready(axi_arready), .full(ar_full), .q(ar_addr_q)
    );

    // Offsets wrap in 32 bits, so addresses below the base land out of range.
    logic [31:0] aw_off, ar_off;
    logic        aw_in_range, ar_in_range;

    assign aw_off      = aw_addr_q - MEM_BASE_ADDR;
    assign ar_off      = ar_addr_q - MEM_BASE_ADDR;
    assign aw_in_range = aw_off < MEM_BYTES;
    assign ar_in_range = ar_off < MEM_BYTES;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   wr_pend, rd_pend;

    assign wr_pend   = aw_full && w_full;
    assign rd_pend   = ar_full;
    assign dbg_state = state;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_RD;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        sram_cen       = 1'b0;
        sram_wen       = 1'b0;
        sram_strb      = 4'h0;
        sram_addr      = '0;
        sram_wdata     = 32'h0;
        unique case (state)
            ST_IDLE: begin
                if (wr_pend && (!rd_pend || last_grant == GRANT_RD)) begin
                    state_nxt      = ST_WR_ACC;
                    last_grant_nxt = GRANT_WR;
                end else if (rd_pend) begin
                    state_nxt      = ST_RD_ACC;
                    last_grant_nxt = GRANT_RD;
                end
            end
            ST_WR_ACC: begin
                if (aw_in_range) begin
                    sram_cen   = 1'b1;
                    sram_wen   = 1'b1;
                    sram_strb  = w_q[35:32];
                    sram_addr  = aw_off[MEM_ADDR_W+1:2];
                    sram_wdata = w_q[31:0];
                end
                state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: if (axi_bready) state_nxt = ST_IDLE;
            ST_RD_ACC: begin
                if (ar_in_range) begin
                    sram_cen  = 1'b1;
                    sram_addr = ar_off[MEM_ADDR_W+1:2];
                end
                state_nxt = ST_RD_RESP;
            end
            ST_RD_RESP: if (axi_rready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign axi_bvalid = (state == ST_WR_RESP);
    assign axi_rvalid = (state == ST_RD_RESP);

    // SRAM data only appears in the first RD_RESP cycle, so it is passed
    // through then and held in rdata_q from that edge onward.
    logic        rd_first;
    logic [31:0] rdata_q, rdata_live;

    assign rdata_live = ar_in_range ? sram_rdata : 32'h0;
    assign axi_rdata  = rd_first ? rdata_live : rdata_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_first <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rd_first <= (state == ST_RD_ACC);
            if (rd_first) rdata_q <= rdata_live;
        end
    end

`ifdef AXI_SRAM_SLAVE_RESP_EN
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            axi_bresp <= AXI_RESP_OKAY;
            axi_rresp <= AXI_RESP_OKAY;
        end else begin
            if (state == ST_WR_ACC) axi_bresp <= aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            if (state == ST_RD_ACC) axi_rresp <= ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot};

endmodule
